// File: rtl/nand_latch_ctrl.sv
// nand_latch_ctrl: sequences timed active-low set/reset pulses onto a bank of
// NAND S/R latch cells for two round-robin requesters. After each pulse it waits
// for the cell to settle, reads the cell back through a 2-flop synchronizer and
// acknowledges the requester with a pass/fail result.
module nand_latch_ctrl #(
    parameter int N          = 8,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2,
    parameter int IW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          op_a,
    input  logic          op_b,
    input  logic [IW-1:0] idx_a,
    input  logic [IW-1:0] idx_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          err,
    output logic          busy,
    output logic [N-1:0]  s_n,
    output logic [N-1:0]  r_n,
    input  logic [N-1:0]  q
);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    localparam int              CNT_MAX     = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int              CW          = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0]   PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [IW:0]     N_LIM       = (IW+1)'(N);

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic            r_op,    w_op;
    logic [IW-1:0]   r_idx,   w_idx;
    logic            r_sel_b, w_sel_b;
    logic            r_prio_b, w_prio_b;
    logic [N-1:0]    r_q_meta, r_q_s;
    logic [N-1:0]    r_s_n,   w_s_n;
    logic [N-1:0]    r_r_n,   w_r_n;
    logic            r_ack_a, w_ack_a;
    logic            r_ack_b, w_ack_b;
    logic            r_err,   w_err;
    logic            r_busy;
    logic            w_grant_b;
    logic            w_illegal;
    logic            w_qbit;

    assign w_illegal = ({1'b0, r_idx} >= N_LIM);

    // Select the synchronized readback bit of the captured cell.
    always_comb begin
        w_qbit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) w_qbit = r_q_s[i];
        end
    end

    // Next-state, capture, arbitration and next registered-output logic.
    // Line decode uses the next-state values so the pulse starts on the grant edge.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_op      = r_op;
        w_idx     = r_idx;
        w_sel_b   = r_sel_b;
        w_prio_b  = r_prio_b;
        w_ack_a   = 1'b0;
        w_ack_b   = 1'b0;
        w_err     = 1'b0;
        w_s_n     = '1;
        w_r_n     = '1;
        w_grant_b = req_b & (~req_a | r_prio_b);

        case (r_state)
            IDLE: begin
                if (!(r_ack_a || r_ack_b) && (req_a || req_b)) begin
                    w_sel_b  = w_grant_b;
                    w_op     = w_grant_b ? op_b  : op_a;
                    w_idx    = w_grant_b ? idx_b : idx_a;
                    w_prio_b = ~w_grant_b;
                    w_cnt    = '0;
                    w_state  = ({1'b0, w_idx} >= N_LIM) ? CHECK : DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_cnt   = '0;
                    w_state = SETTLE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt   = '0;
                    w_state = CHECK;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            CHECK: begin
                w_state = IDLE;
                w_ack_a = ~r_sel_b;
                w_ack_b = r_sel_b;
                w_err   = w_illegal | (w_qbit != r_op);
            end
            default: w_state = IDLE;
        endcase

        if (w_state == DRIVE) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (w_idx == IW'(i)) begin
                    if (w_op) w_s_n[i] = 1'b0;
                    else      w_r_n[i] = 1'b0;
                end
            end
        end
    end

    // State, transaction capture and registered outputs; reset releases all lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_sel_b  <= 1'b0;
            r_prio_b <= 1'b0;
            r_s_n    <= '1;
            r_r_n    <= '1;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_op     <= w_op;
            r_idx    <= w_idx;
            r_sel_b  <= w_sel_b;
            r_prio_b <= w_prio_b;
            r_s_n    <= w_s_n;
            r_r_n    <= w_r_n;
            r_ack_a  <= w_ack_a;
            r_ack_b  <= w_ack_b;
            r_err    <= w_err;
            r_busy   <= (w_state != IDLE);
        end
    end

    // Two-flop synchronizer for the asynchronous latch readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_meta <= '0;
            r_q_s    <= '0;
        end else begin
            r_q_meta <= q;
            r_q_s    <= r_q_meta;
        end
    end

    assign s_n   = r_s_n;
    assign r_n   = r_r_n;
    assign ack_a = r_ack_a;
    assign ack_b = r_ack_b;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule

// File: tb/tb_nand_latch_ctrl.sv
// Directed bench for nand_latch_ctrl with a behavioural NAND latch bank,
// a queue of expected acknowledgements and a per-cycle line invariant check.
module tb_nand_latch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, op_a, op_b;
    logic [3:0] idx_a, idx_b;
    logic       ack_a, ack_b, err, busy;
    logic [7:0] s_n, r_n, q;
    logic [7:0] lat   = '0;
    logic [7:0] stuck = '0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] sb[$];   // expected {ack_a, ack_b, err}

    nand_latch_ctrl #(.N(8), .PULSE_CYC(2), .SETTLE_CYC(2), .IW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
        .idx_a(idx_a), .idx_b(idx_b),
        .ack_a(ack_a), .ack_b(ack_b), .err(err), .busy(busy),
        .s_n(s_n), .r_n(r_n), .q(q)
    );

    always #5 clk = ~clk;

    // Latch bank: a low s_n sets the cell, a low r_n clears it; stuck cells read 0.
    always @(s_n or r_n) begin
        for (int i = 0; i < 8; i++) begin
            if (!s_n[i])      lat[i] = 1'b1;
            else if (!r_n[i]) lat[i] = 1'b0;
        end
    end
    assign q = lat & ~stuck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // At most one line low in total, which also excludes s_n[i]/r_n[i] low together.
    always @(negedge clk) begin
        if (rst_n) check("one_line_low", 32'($countones({~s_n, ~r_n}) <= 1), 1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input int exp_ticks);
        int n;
        logic got;
        logic [2:0] exp;
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            tick();
            n++;
            got = ack_a | ack_b;
        end
        check({tag, "_ack_seen"}, got, 1);
        if (got) begin
            check({tag, "_latency"}, n, exp_ticks);
            check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check({tag, "_ack_err"}, {ack_a, ack_b, err}, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0;
        idx_a = '0;   idx_b = '0;
        repeat (2) @(negedge clk);
        check("rst_s_n", s_n, 8'hFF);
        check("rst_r_n", r_n, 8'hFF);
        check("rst_outs", {ack_a, ack_b, err, busy}, 4'b0000);
        rst_n = 1'b1;

        // Single set of cell 3 by A: pulse for two cycles, ack after E5.
        req_a = 1'b1; op_a = 1'b1; idx_a = 4'd3; sb.push_back(3'b100);
        tick();
        check("set_E0_s_n", s_n, 8'hF7);
        check("set_E0_r_n", r_n, 8'hFF);
        check("set_E0_busy", busy, 1);
        tick();
        check("set_E1_s_n", s_n, 8'hF7);
        tick();
        check("set_E2_s_n", s_n, 8'hFF);
        wait_ack("set", 3);
        req_a = 1'b0;
        tick();
        check("set_E6_idle", {ack_a, busy, s_n, r_n}, {2'b00, 16'hFFFF});

        // Stuck cell 6: B sets it, readback stays 0.
        stuck[6] = 1'b1;
        req_b = 1'b1; op_b = 1'b1; idx_b = 4'd6; sb.push_back(3'b011);
        tick();
        check("stuck_E0_s_n", s_n, 8'hBF);
        wait_ack("stuck", 5);
        req_b = 1'b0;
        tick();

        // Illegal index: straight to CHECK, no line driven, ack after E1.
        req_a = 1'b1; op_a = 1'b1; idx_a = 4'd9; sb.push_back(3'b101);
        tick();
        check("ill_E0_lines", {s_n, r_n}, 16'hFFFF);
        check("ill_E0_busy", busy, 1);
        wait_ack("ill", 1);
        check("ill_E1_lines", {s_n, r_n}, 16'hFFFF);
        req_a = 1'b0;
        tick();

        // Back-to-back: A keeps req high through its ack.
        req_a = 1'b1; op_a = 1'b0; idx_a = 4'd3; sb.push_back(3'b100);
        wait_ack("b2b_first", 6);
        op_a = 1'b1; idx_a = 4'd2; sb.push_back(3'b100);
        tick();
        check("b2b_ackcycle", {ack_a, busy, s_n}, {2'b00, 8'hFF});
        tick();
        check("b2b_regrant_s_n", s_n, 8'hFB);
        check("b2b_regrant_busy", busy, 1);
        wait_ack("b2b_second", 5);
        req_a = 1'b0;
        tick();

        // Asynchronous reset mid-pulse; pointer currently favours B.
        req_a = 1'b1; op_a = 1'b1; idx_a = 4'd5; sb.push_back(3'b100);
        tick();
        check("rmid_E0_s_n", s_n, 8'hDF);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_s_n", s_n, 8'hFF);
        check("rmid_r_n", r_n, 8'hFF);
        check("rmid_outs", {ack_a, ack_b, err, busy}, 4'b0000);
        void'(sb.pop_back());
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Tie after reset: A wins, B follows at the first IDLE edge after ack_a.
        req_a = 1'b1; op_a = 1'b1; idx_a = 4'd1;
        req_b = 1'b1; op_b = 1'b0; idx_b = 4'd1;
        sb.push_back(3'b100);
        sb.push_back(3'b010);
        tick();
        check("tie_E0_s_n", s_n, 8'hFD);
        check("tie_E0_r_n", r_n, 8'hFF);
        wait_ack("tie_a", 5);
        req_a = 1'b0;
        tick();
        check("tie_ackcycle", {busy, r_n}, {1'b0, 8'hFF});
        tick();
        check("tie_b_r_n", r_n, 8'hFD);
        check("tie_b_s_n", s_n, 8'hFF);
        wait_ack("tie_b", 5);
        req_b = 1'b0;
        tick();

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/nand_latch_ctrl.md
# nand_latch_ctrl

Synchronous sequencer that shares a bank of N cross-coupled NAND set/reset latch cells between two requesters. It turns a requester's set or reset command into a timed active-low pulse on exactly one cell. It then waits for the cell to settle, reads the cell back through a synchronizer, and acknowledges the requester with a pass/fail result. It sits between clocked control logic and the asynchronous latch bank, and it is the only block allowed to drive the bank's s/r inputs.

## Interface
- N, 8: number of latch cells in the bank; legal range 2–16.
- PULSE_CYC, 2: cycles the selected s_n/r_n line is held low; must be 1 or more.
- SETTLE_CYC, 2: cycles waited after the pulse before readback; must be 2 or more to cover the synchronizer.
- IW, 4: width of the index inputs; 2^IW must be at least N.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a / req_b  in  1  request from requester A / B; held high until that requester's ack.
- op_a / op_b  in  1  requested operation: 1 = set (drive s_n), 0 = reset (drive r_n).
- idx_a / idx_b  in  IW  target cell index.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- err  out  1  valid only while an ack is high; 1 = readback mismatch or illegal index.
- busy  out  1  high whenever the FSM is not in IDLE.
- s_n  out  N  active-low set lines to the latch bank; idle value is all ones.
- r_n  out  N  active-low reset lines to the latch bank; idle value is all ones.
- q  in  N  latch readback, asynchronous; q[i]=1 means cell i is set.

## Operation
- Reset values: s_n and r_n all ones, ack_a = ack_b = 0, err = 0, busy = 0, state IDLE, round-robin pointer favours A, synchronizer flops cleared. Reset applies asynchronously, including mid-pulse, so any low line releases immediately.
- q passes through a 2-flop synchronizer. Only the synchronized value, q_s, is compared.
- FSM states and transitions:
  - IDLE: if any ack is high this cycle, no grant. Otherwise, if req_a or req_b is high, grant one requester, capture its op and idx, and go to DRIVE. If the captured idx is N or greater, go to CHECK with a forced error.
  - DRIVE: drive s_n[idx] = 0 (op = 1) or r_n[idx] = 0 (op = 0) for PULSE_CYC cycles, then go to SETTLE.
  - SETTLE: all lines high for SETTLE_CYC cycles, then go to CHECK.
  - CHECK: compare q_s[idx] with op. Go to IDLE and register the served requester's ack = 1 and err = (mismatch or illegal index) for the next cycle.
- Arbitration:
  - If only one request is pending, grant it.
  - If both are pending, grant the requester that was not served last. After reset, A wins the first tie.
  - The pointer updates at every grant.
- Invariants:
  - At most one bit of s_n and r_n combined is low at any time.
  - s_n[i] and r_n[i] are never low together. This keeps the forbidden both-inputs-low NAND condition off every cell.
  - No line is driven low outside DRIVE.
- The captured op and idx are used for the whole transaction. Changes on the request inputs after the grant are ignored.
- A requester must drop req in the cycle after its ack. If req is still high after the one-cycle ack turnaround, it is treated as a new request.

## Timing
- s_n, r_n, ack, err and busy are all registered; there are no combinational input-to-output paths.
- Call the grant edge E0 (IDLE samples req):
  - drive line low after edges E0 … E(PULSE_CYC−1);
  - drive line high after edge E(PULSE_CYC);
  - CHECK after edge E(PULSE_CYC+SETTLE_CYC);
  - ack high for one cycle after edge E(PULSE_CYC+SETTLE_CYC+1).
  - With the defaults, ack is high after E5.
- Illegal index: CHECK after E0, ack with err = 1 after E1, and no line is driven.
- Minimum spacing between grants is PULSE_CYC+SETTLE_CYC+3 edges, because the ack cycle blocks a grant.
- The losing requester of a tie is granted at the first IDLE edge after the winner's ack cycle.

## Test plan
- Reset: assert rst_n = 0 mid-DRIVE on a set of idx 5 → s_n = 8'hFF asynchronously; ack, err and busy are 0. After release, the first tie is granted to A.
- Single set: A requests op = 1, idx = 3, with the bank model returning q[3] = 1 → s_n = 8'hF7 for exactly 2 cycles after E0, ack_a after E5, err = 0, r_n stays 8'hFF.
- Tie and fairness: A (op = 1, idx = 1) and B (op = 0, idx = 1) assert together after reset → A is served first (s_n = 8'hFD). B is granted at the first IDLE edge after ack_a (r_n = 8'hFD) and gets ack_b with err = 0. s_n[1] and r_n[1] are never both 0.
- Stuck cell: B requests op = 1, idx = 6, with q[6] held at 0 → ack_b with err = 1 after E5.
- Illegal index: A requests idx = 9 with N = 8 → ack_a with err = 1 after E1; s_n and r_n stay 8'hFF throughout.
- Back-to-back: A holds req through its ack → no grant in the ack cycle, and a second grant at the next edge.
